// File: rtl/fpcvt_pkg.sv
// Shared field widths and packed-float layout for the linear-to-FP convert path.
// Value of a packed float is sig x 2^exp with a separate sign bit.
package fpcvt_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'd15;
  // Significand after a rounding carry-out: 16 x 2^e == 8 x 2^(e+1)
  localparam logic [SIG_W-1:0] SIG_RENORM = 4'b1000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_t;

endpackage

// File: rtl/fp_round.sv
// Round-half-up on magnitude with renormalisation on carry-out and clamp at
// the largest representable magnitude.
module fp_round
  import fpcvt_pkg::*;
(
  input  logic [EXP_W-1:0] i_exp,
  input  logic [SIG_W-1:0] i_sig,
  input  logic             i_rnd,
  output logic [EXP_W-1:0] o_exp,
  output logic [SIG_W-1:0] o_sig,
  output logic             o_sat
);

  logic [SIG_W:0] w_sum;

  always_comb begin
    w_sum = {1'b0, i_sig} + {{SIG_W{1'b0}}, i_rnd};
    o_exp = i_exp;
    o_sig = w_sum[SIG_W-1:0];
    o_sat = 1'b0;
    if (w_sum[SIG_W]) begin
      if (i_exp == EXP_MAX) begin
        o_sig = SIG_MAX;
        o_sat = 1'b1;
      end else begin
        o_exp = i_exp + 1'b1;
        o_sig = SIG_RENORM;
      end
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack pipeline: S1 captures converted fields, S2 holds
// the rounded packed float. Counts saturated results delivered downstream.
module fp_round_pack
  import fpcvt_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_fp,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt
);

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [EXP_W-1:0] r_s1_exp;
  logic [SIG_W-1:0] r_s1_sig;
  logic             r_s1_rnd;

  logic             r_s2_valid;
  fp_t              r_s2_fp;
  logic             r_s2_sat;
  logic [CNT_W-1:0] r_sat_cnt;

  logic             w_s2_load;
  logic [EXP_W-1:0] w_exp;
  logic [SIG_W-1:0] w_sig;
  logic             w_sat;
  fp_t              w_s2_fp;
  logic             w_s2_sat;
  logic             w_emit_sat;

  fp_round u_fp_round (
    .i_exp (r_s1_exp),
    .i_sig (r_s1_sig),
    .i_rnd (r_s1_rnd),
    .o_exp (w_exp),
    .o_sig (w_sig),
    .o_sat (w_sat)
  );

  assign in_ready   = !rst && (!r_s1_valid || !r_s2_valid || out_ready);
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_emit_sat = r_s2_valid && out_ready && r_s2_sat;

  // An empty S1 loads zeros into S2 so the output bus idles at 0
  always_comb begin
    w_s2_fp  = '0;
    w_s2_sat = 1'b0;
    if (r_s1_valid) begin
      w_s2_fp.sign = r_s1_sign;
      w_s2_fp.exp  = w_exp;
      w_s2_fp.sig  = w_sig;
      w_s2_sat     = w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_sig   <= '0;
      r_s1_rnd   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_fp    <= '0;
      r_s2_sat   <= 1'b0;
      r_sat_cnt  <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        r_s1_sign  <= in_sign;
        r_s1_exp   <= in_exp;
        r_s1_sig   <= in_sig;
        r_s1_rnd   <= in_rnd;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        r_s2_fp    <= w_s2_fp;
        r_s2_sat   <= w_s2_sat;
      end
      if (w_emit_sat && (r_sat_cnt != '1)) begin
        r_sat_cnt <= r_sat_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_fp    = r_s2_fp;
  assign out_sat   = r_s2_sat;
  assign sat_cnt   = r_sat_cnt;

endmodule
